// File: rtl/pll_seq_pkg.sv
// Shared types and width helpers for the PLL lock sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RESET_HOLD = 3'd0,
        WAIT_LOCK  = 3'd1,
        STABLE     = 3'd2,
        READY      = 3'd3,
        FAULT      = 3'd4
    } seq_state_e;

    // One shared timer must reach the largest of the three terminal counts minus one.
    function automatic int timer_width(input int rst_cycles, input int lock_timeout,
                                       input int stable_cycles);
        int m;
        m = rst_cycles;
        if (lock_timeout > m) m = lock_timeout;
        if (stable_cycles > m) m = stable_cycles;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    function automatic int count_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous status bit; clears to 0 on reset.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: holds the PLL in reset, waits for a debounced lock, retries, faults.
// Optional macro PLL_LOCK_LOSS_CNT_EN adds a saturating lock_loss_cnt output.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 64,
    parameter int MAX_RETRIES   = 3,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                                 refclk,
    input  logic                                 rst,
    input  logic                                 pll_locked,
    input  logic                                 restart,
    output logic                                 pll_rst,
    output logic                                 ready,
    output logic                                 fault,
    output logic [2:0]                           seq_state,
    output logic [count_width(MAX_RETRIES)-1:0]  retry_cnt
`ifdef PLL_LOCK_LOSS_CNT_EN
    ,
    output logic [7:0]                           lock_loss_cnt
`endif
);

    localparam int TIMER_W = timer_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int RETRY_W = count_width(MAX_RETRIES);

    localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

    seq_state_e         state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               pll_rst_q, pll_rst_d;
    logic               ready_q, ready_d;
    logic               fault_q, fault_d;
    logic               locked_s;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (refclk),
        .rst_n (rst),
        .d_i   (pll_locked),
        .q_o   (locked_s)
    );

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;

        case (state_q)
            RESET_HOLD: begin
                if (timer_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABLE;
                end else if (timer_q == TIMEOUT_LAST) begin
                    if (retry_q == RETRY_MAX) begin
                        state_d = FAULT;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        state_d = RESET_HOLD;
                    end
                end
            end
            STABLE: begin
                if (!locked_s)                  state_d = WAIT_LOCK;
                else if (timer_q == STABLE_LAST) state_d = READY;
            end
            READY: begin
                // Loss of lock re-sequences from scratch and is not charged as a retry.
                if (!locked_s) begin
                    state_d = RESET_HOLD;
                    retry_d = '0;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = RESET_HOLD;
            end
        endcase

        if (restart) begin
            state_d = RESET_HOLD;
            retry_d = '0;
        end

        // A restart re-enters RESET_HOLD even from RESET_HOLD, so it also clears the timer.
        timer_d   = (restart || (state_d != state_q)) ? '0 : timer_q + 1'b1;
        pll_rst_d = (state_d == RESET_HOLD) || (state_d == FAULT);
        ready_d   = (state_d == READY);
        fault_d   = (state_d == FAULT);
    end

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            state_q   <= RESET_HOLD;
            timer_q   <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            pll_rst_q <= pll_rst_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
        end
    end

`ifdef PLL_LOCK_LOSS_CNT_EN
    logic [7:0] loss_q, loss_d;
    logic       lock_lost;

    assign lock_lost = (state_q == READY) && !locked_s && !restart;

    always_comb begin
        loss_d = loss_q;
        if (lock_lost && (loss_q != 8'hFF)) loss_d = loss_q + 8'd1;
    end

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            loss_q <= 8'd0;
        end else begin
            loss_q <= loss_d;
        end
    end

    assign lock_loss_cnt = loss_q;
`endif

    assign pll_rst   = pll_rst_q;
    assign ready     = ready_q;
    assign fault     = fault_q;
    assign seq_state = state_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: a vector table for the locked path plus hand sequences.
module tb_pll_lock_sequencer;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 32;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 2;
    localparam int SYNC_STAGES   = 2;

    logic       refclk = 1'b0;
    logic       rst = 1'b0;
    logic       pll_locked = 1'b0;
    logic       restart = 1'b0;
    logic       pll_rst, ready, fault;
    logic [2:0] seq_state;
    logic [1:0] retry_cnt;
`ifdef PLL_LOCK_LOSS_CNT_EN
    logic [7:0] lock_loss_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    pll_lock_sequencer #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRIES   (MAX_RETRIES),
        .SYNC_STAGES   (SYNC_STAGES)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .restart    (restart),
        .pll_rst    (pll_rst),
        .ready      (ready),
        .fault      (fault),
        .seq_state  (seq_state),
        .retry_cnt  (retry_cnt)
`ifdef PLL_LOCK_LOSS_CNT_EN
        ,
        .lock_loss_cnt (lock_loss_cnt)
`endif
    );

    always #5 refclk = ~refclk;

    typedef struct {
        logic       locked;
        logic       rstrt;
        int         adv;
        logic       e_pll_rst;
        logic       e_ready;
        logic       e_fault;
        logic [2:0] e_state;
        logic [1:0] e_retry;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_outs(input string tag, input logic e_pll_rst, input logic e_ready,
                              input logic e_fault, input logic [2:0] e_state,
                              input logic [1:0] e_retry);
        check({tag, ".pll_rst"},   32'(pll_rst),   32'(e_pll_rst));
        check({tag, ".ready"},     32'(ready),     32'(e_ready));
        check({tag, ".fault"},     32'(fault),     32'(e_fault));
        check({tag, ".seq_state"}, 32'(seq_state), 32'(e_state));
        check({tag, ".retry_cnt"}, 32'(retry_cnt), 32'(e_retry));
    endtask

    // Advance n rising edges and settle just after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    // Releases reset just after an edge; the next rising edge is edge 1 of the sequence.
    task automatic do_reset(input logic locked);
        rst        = 1'b0;
        restart    = 1'b0;
        pll_locked = locked;
        step(3);
        rst = 1'b1;
    endtask

    initial begin
        // Locked PLL from release: ready at edge 13, loss of lock, re-lock, then a restart from READY.
        vecs[0]  = '{1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0};
        vecs[1]  = '{1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0};
        vecs[2]  = '{1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 3'd1, 2'd0};
        vecs[3]  = '{1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 3'd2, 2'd0};
        vecs[4]  = '{1'b1, 1'b0, 7, 1'b0, 1'b0, 1'b0, 3'd2, 2'd0};
        vecs[5]  = '{1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0, 3'd3, 2'd0};
        vecs[6]  = '{1'b1, 1'b0, 7, 1'b0, 1'b1, 1'b0, 3'd3, 2'd0};
        vecs[7]  = '{1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b0, 3'd3, 2'd0};
        vecs[8]  = '{1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0};
        vecs[9]  = '{1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0};
        vecs[10] = '{1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 3'd1, 2'd0};
        vecs[11] = '{1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 3'd2, 2'd0};
        vecs[12] = '{1'b1, 1'b0, 8, 1'b0, 1'b1, 1'b0, 3'd3, 2'd0};
        vecs[13] = '{1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0};
        vecs[14] = '{1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0};
        vecs[15] = '{1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 3'd1, 2'd0};
        vecs[16] = '{1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 3'd2, 2'd0};
        vecs[17] = '{1'b1, 1'b0, 8, 1'b0, 1'b1, 1'b0, 3'd3, 2'd0};

        rst        = 1'b0;
        pll_locked = 1'b1;
        step(2);
        check_outs("reset", 1'b1, 1'b0, 1'b0, 3'd0, 2'd0);
        rst = 1'b1;

        for (int i = 0; i < 18; i++) begin
            pll_locked = vecs[i].locked;
            restart    = vecs[i].rstrt;
            step(vecs[i].adv);
            check_outs($sformatf("vec%0d", i), vecs[i].e_pll_rst, vecs[i].e_ready,
                       vecs[i].e_fault, vecs[i].e_state, vecs[i].e_retry);
        end
        restart = 1'b0;
`ifdef PLL_LOCK_LOSS_CNT_EN
        check("lock_loss_cnt", 32'(lock_loss_cnt), 32'd1);
`endif

        // Never locks: three 36-cycle attempts, then FAULT until restart.
        do_reset(1'b0);
        step(4);   check_outs("to_e4",   1'b0, 1'b0, 1'b0, 3'd1, 2'd0);
        step(31);  check_outs("to_e35",  1'b0, 1'b0, 1'b0, 3'd1, 2'd0);
        step(1);   check_outs("to_e36",  1'b1, 1'b0, 1'b0, 3'd0, 2'd1);
        step(4);   check_outs("to_e40",  1'b0, 1'b0, 1'b0, 3'd1, 2'd1);
        step(31);  check_outs("to_e71",  1'b0, 1'b0, 1'b0, 3'd1, 2'd1);
        step(1);   check_outs("to_e72",  1'b1, 1'b0, 1'b0, 3'd0, 2'd2);
        step(35);  check_outs("to_e107", 1'b0, 1'b0, 1'b0, 3'd1, 2'd2);
        step(1);   check_outs("to_e108", 1'b1, 1'b0, 1'b1, 3'd4, 2'd2);
        step(12);  check_outs("to_e120", 1'b1, 1'b0, 1'b1, 3'd4, 2'd2);
        restart = 1'b1;
        step(1);   check_outs("fault_restart", 1'b1, 1'b0, 1'b0, 3'd0, 2'd0);
        restart = 1'b0;

        // Restart coincides with the WAIT_LOCK timeout edge: no retry is charged.
        step(4);   check_outs("rt_e125", 1'b0, 1'b0, 1'b0, 3'd1, 2'd0);
        step(31);  check_outs("rt_e156", 1'b0, 1'b0, 1'b0, 3'd1, 2'd0);
        restart = 1'b1;
        step(1);   check_outs("rt_e157", 1'b1, 1'b0, 1'b0, 3'd0, 2'd0);
        restart = 1'b0;
        step(3);   check_outs("rt_e160", 1'b1, 1'b0, 1'b0, 3'd0, 2'd0);
        step(1);   check_outs("rt_e161", 1'b0, 1'b0, 1'b0, 3'd1, 2'd0);

        // Lock for 5 cycles, one-cycle glitch, then clean lock.
        do_reset(1'b0);
        step(4);   check_outs("gl_e4",  1'b0, 1'b0, 1'b0, 3'd1, 2'd0);
        pll_locked = 1'b1;
        step(5);   check_outs("gl_e9",  1'b0, 1'b0, 1'b0, 3'd2, 2'd0);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(2);   check_outs("gl_e12", 1'b0, 1'b0, 1'b0, 3'd1, 2'd0);
        step(1);   check_outs("gl_e13", 1'b0, 1'b0, 1'b0, 3'd2, 2'd0);
        step(7);   check_outs("gl_e20", 1'b0, 1'b0, 1'b0, 3'd2, 2'd0);
        step(1);   check_outs("gl_e21", 1'b0, 1'b1, 1'b0, 3'd3, 2'd0);

        // Asynchronous reset in the middle of STABLE, then a normal sequence.
        do_reset(1'b1);
        step(7);   check_outs("ar_e7", 1'b0, 1'b0, 1'b0, 3'd2, 2'd0);
        rst = 1'b0;
        #1;        check_outs("ar_async", 1'b1, 1'b0, 1'b0, 3'd0, 2'd0);
        step(2);
        rst = 1'b1;
        step(12);  check_outs("ar_e12", 1'b0, 1'b0, 1'b0, 3'd2, 2'd0);
        step(1);   check_outs("ar_e13", 1'b0, 1'b1, 1'b0, 3'd3, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
